// File: rtl/pi_digit_sched_pkg.sv
// Shared types and constants for the pi digit store scheduler.
// Address layout, FSM states and small helpers used by the scheduler and the DPD unpacker.
package pi_digit_sched_pkg;

    localparam int unsigned PI_NUM_GROUPS = 467;
    localparam int unsigned GROUP_W       = 10;
    localparam int unsigned SEL_W         = 2;
    localparam int unsigned ADDR_W        = GROUP_W + SEL_W;
    localparam int unsigned DIGIT_W       = 4;
    localparam int unsigned DPD_W         = 10;
    localparam int unsigned NUM_PORTS     = 2;

    localparam logic [SEL_W-1:0] SEL_INVALID = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    // Requester address: group index in the upper bits, digit select in the lower bits.
    typedef struct packed {
        logic [GROUP_W-1:0] group;
        logic [SEL_W-1:0]   sel;
    } digit_addr_t;

    // Element [0] is the hundreds digit, matching sel 0.
    typedef logic [0:2][DIGIT_W-1:0] triplet_t;

    function automatic logic addr_invalid(digit_addr_t a, int unsigned num_groups);
        return (a.sel == SEL_INVALID) || (32'(a.group) >= num_groups);
    endfunction

    function automatic logic [DIGIT_W-1:0] pick_digit(triplet_t t, logic [SEL_W-1:0] sel);
        logic [DIGIT_W-1:0] d;
        case (sel)
            2'd0:    d = t[0];
            2'd1:    d = t[1];
            default: d = t[2];
        endcase
        return d;
    endfunction

endpackage

// File: rtl/pi_digit_sched_unpack.sv
// Combinational densely-packed-decimal decoder: one 10-bit DPD code to three BCD digits.
// Non-canonical codes decode through the same equations without clamping.
module pi_dpd_unpack
    import pi_digit_sched_pkg::*;
(
    input  logic [DPD_W-1:0]   code_i,
    output logic [DIGIT_W-1:0] hund_o,
    output logic [DIGIT_W-1:0] tens_o,
    output logic [DIGIT_W-1:0] ones_o
);

    // Bit 3 flags a large digit; bits 2:1 (and 6:5 when both are set) say which ones.
    always_comb begin
        hund_o = {1'b0, code_i[9:7]};
        tens_o = {1'b0, code_i[6:4]};
        ones_o = {1'b0, code_i[2:0]};
        if (code_i[3]) begin
            case (code_i[2:1])
                2'b00: begin
                    ones_o = {3'b100, code_i[0]};
                end
                2'b01: begin
                    tens_o = {3'b100, code_i[4]};
                    ones_o = {1'b0, code_i[6:5], code_i[0]};
                end
                2'b10: begin
                    hund_o = {3'b100, code_i[7]};
                    ones_o = {1'b0, code_i[9:8], code_i[0]};
                end
                default: begin
                    case (code_i[6:5])
                        2'b00: begin
                            hund_o = {3'b100, code_i[7]};
                            tens_o = {3'b100, code_i[4]};
                            ones_o = {1'b0, code_i[9:8], code_i[0]};
                        end
                        2'b01: begin
                            hund_o = {3'b100, code_i[7]};
                            tens_o = {1'b0, code_i[9:8], code_i[4]};
                            ones_o = {3'b100, code_i[0]};
                        end
                        2'b10: begin
                            tens_o = {3'b100, code_i[4]};
                            ones_o = {3'b100, code_i[0]};
                        end
                        default: begin
                            hund_o = {3'b100, code_i[7]};
                            tens_o = {3'b100, code_i[4]};
                            ones_o = {3'b100, code_i[0]};
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: rtl/pi_digit_sched.sv
// Two-port round-robin scheduler in front of the DPD triplet ROM.
// Keeps a one-entry triplet cache; one request in flight, one registered response per request.
module pi_digit_sched
    import pi_digit_sched_pkg::*;
#(
    parameter int unsigned NUM_GROUPS = PI_NUM_GROUPS,
    parameter int unsigned ROM_LAT    = 1
) (
    input  logic               clk,
    input  logic               reset_n,

    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [ADDR_W-1:0]  req0_addr,
    output logic               rsp0_valid,
    output logic [DIGIT_W-1:0] rsp0_digit,
    output logic               rsp0_err,

    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [ADDR_W-1:0]  req1_addr,
    output logic               rsp1_valid,
    output logic [DIGIT_W-1:0] rsp1_digit,
    output logic               rsp1_err,

    output logic               rom_en,
    output logic [GROUP_W-1:0] rom_addr,
    input  logic [DPD_W-1:0]   rom_code
);

    localparam int unsigned CNT_W = 2;

    state_e                              state_q, state_d;
    logic                                last_q, last_d;
    logic                                port_q, port_d;
    digit_addr_t                         addr_q, addr_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic                                cache_vld_q, cache_vld_d;
    logic [GROUP_W-1:0]                  cache_tag_q, cache_tag_d;
    triplet_t                            cache_dig_q, cache_dig_d;
    logic                                rom_en_q, rom_en_d;
    logic [GROUP_W-1:0]                  rom_addr_q, rom_addr_d;
    logic [NUM_PORTS-1:0]                rsp_valid_q, rsp_valid_d;
    logic [NUM_PORTS-1:0][DIGIT_W-1:0]   rsp_digit_q, rsp_digit_d;
    logic [NUM_PORTS-1:0]                rsp_err_q, rsp_err_d;

    logic                                gnt_vld_c;
    logic                                gnt_c;
    logic                                accept_c;
    digit_addr_t                         req_addr_c;
    logic [DIGIT_W-1:0]                  rom_hund_c, rom_tens_c, rom_ones_c;
    triplet_t                            rom_dig_c;

    // Round-robin: on contention the port that did not win last time gets the grant.
    always_comb begin
        gnt_vld_c = req0_valid || req1_valid;
        gnt_c     = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_c = ~last_q;
        end else if (req1_valid) begin
            gnt_c = 1'b1;
        end
    end

    assign accept_c   = (state_q == ST_IDLE) && gnt_vld_c;
    assign req_addr_c = digit_addr_t'(gnt_c ? req1_addr : req0_addr);

    // Ready is held low while reset is asserted even if a requester is already valid.
    assign req0_ready = reset_n && accept_c && !gnt_c;
    assign req1_ready = reset_n && accept_c && gnt_c;

    pi_dpd_unpack u_unpack (
        .code_i (rom_code),
        .hund_o (rom_hund_c),
        .tens_o (rom_tens_c),
        .ones_o (rom_ones_c)
    );

    assign rom_dig_c = {rom_hund_c, rom_tens_c, rom_ones_c};

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        port_d      = port_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        cache_vld_d = cache_vld_q;
        cache_tag_d = cache_tag_q;
        cache_dig_d = cache_dig_q;
        rom_en_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        rsp_valid_d = '0;
        rsp_digit_d = '0;
        rsp_err_d   = '0;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    last_d = gnt_c;
                    port_d = gnt_c;
                    addr_d = req_addr_c;
                    cnt_d  = '0;
                    if (addr_invalid(req_addr_c, NUM_GROUPS)) begin
                        state_d            = ST_RESP;
                        rsp_valid_d[gnt_c] = 1'b1;
                        rsp_err_d[gnt_c]   = 1'b1;
                    end else if (cache_vld_q && (cache_tag_q == req_addr_c.group)) begin
                        state_d            = ST_RESP;
                        rsp_valid_d[gnt_c] = 1'b1;
                        rsp_digit_d[gnt_c] = pick_digit(cache_dig_q, req_addr_c.sel);
                    end else begin
                        state_d    = ST_FETCH;
                        rom_en_d   = 1'b1;
                        rom_addr_d = req_addr_c.group;
                    end
                end
            end
            ST_FETCH: begin
                // cnt_q counts cycles since rom_en; the code is valid when it equals the latency.
                if (cnt_q == CNT_W'(ROM_LAT)) begin
                    state_d             = ST_RESP;
                    cache_vld_d         = 1'b1;
                    cache_tag_d         = addr_q.group;
                    cache_dig_d         = rom_dig_c;
                    rsp_valid_d[port_q] = 1'b1;
                    rsp_digit_d[port_q] = pick_digit(rom_dig_c, addr_q.sel);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            port_q      <= 1'b0;
            addr_q      <= '0;
            cnt_q       <= '0;
            cache_vld_q <= 1'b0;
            cache_tag_q <= '0;
            cache_dig_q <= '0;
            rom_en_q    <= 1'b0;
            rom_addr_q  <= '0;
            rsp_valid_q <= '0;
            rsp_digit_q <= '0;
            rsp_err_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            port_q      <= port_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            cache_vld_q <= cache_vld_d;
            cache_tag_q <= cache_tag_d;
            cache_dig_q <= cache_dig_d;
            rom_en_q    <= rom_en_d;
            rom_addr_q  <= rom_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_digit_q <= rsp_digit_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rom_en     = rom_en_q;
    assign rom_addr   = rom_addr_q;
    assign rsp0_valid = rsp_valid_q[0];
    assign rsp0_digit = rsp_digit_q[0];
    assign rsp0_err   = rsp_err_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp1_digit = rsp_digit_q[1];
    assign rsp1_err   = rsp_err_q[1];

endmodule

// File: tb/tb_pi_digit_sched.sv
// Scoreboard bench for pi_digit_sched: a ROM_LAT=1 instance for the main scenarios
// and a ROM_LAT=3 instance for the long-latency miss.
`timescale 1ns/1ps
module tb_pi_digit_sched;
    import pi_digit_sched_pkg::*;

    typedef struct {
        int port;
        int digit;
        int err;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // ROM_LAT = 1 instance
    logic        r0v = 1'b0, r1v = 1'b0;
    logic [11:0] r0a = '0, r1a = '0;
    logic        r0r, r1r, s0v, s1v, s0e, s1e;
    logic [3:0]  s0d, s1d;
    logic        rom_en;
    logic [9:0]  rom_addr, rom_code;

    // ROM_LAT = 3 instance
    logic        q0v = 1'b0;
    logic [11:0] q0a = '0;
    logic        q0r, q1r, t0v, t1v, t0e, t1e;
    logic [3:0]  t0d, t1d;
    logic        rom3_en;
    logic [9:0]  rom3_addr, rom3_code;

    pi_digit_sched #(.NUM_GROUPS(467), .ROM_LAT(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(r0v), .req0_ready(r0r), .req0_addr(r0a),
        .rsp0_valid(s0v), .rsp0_digit(s0d), .rsp0_err(s0e),
        .req1_valid(r1v), .req1_ready(r1r), .req1_addr(r1a),
        .rsp1_valid(s1v), .rsp1_digit(s1d), .rsp1_err(s1e),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_code(rom_code)
    );

    pi_digit_sched #(.NUM_GROUPS(467), .ROM_LAT(3)) dut3 (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(q0v), .req0_ready(q0r), .req0_addr(q0a),
        .rsp0_valid(t0v), .rsp0_digit(t0d), .rsp0_err(t0e),
        .req1_valid(1'b0), .req1_ready(q1r), .req1_addr(12'h000),
        .rsp1_valid(t1v), .rsp1_digit(t1d), .rsp1_err(t1e),
        .rom_en(rom3_en), .rom_addr(rom3_addr), .rom_code(rom3_code)
    );

    // ROM contents: decimal triplet per group, pi digits for the first groups.
    function automatic int rom_num(int g);
        case (g)
            0:       return 314;
            1:       return 159;
            2:       return 265;
            466:     return 897;
            default: return (g * 37 + 11) % 1000;
        endcase
    endfunction

    function automatic int exp_digit(int g, int s);
        int n;
        n = rom_num(g);
        if (s == 0) return n / 100;
        if (s == 1) return (n / 10) % 10;
        return n % 10;
    endfunction

    // DPD encoder (digits abcd efgh ijkm, a/e/i the large-digit flags).
    function automatic logic [9:0] dpd_enc(int n);
        logic [3:0] d2, d1, d0;
        logic [9:0] c;
        d2 = 4'(n / 100);
        d1 = 4'((n / 10) % 10);
        d0 = 4'(n % 10);
        case ({d2[3], d1[3], d0[3]})
            3'b000:  c = {d2[2:0], d1[2:0], 1'b0, d0[2:0]};
            3'b001:  c = {d2[2:0], d1[2:0], 1'b1, 2'b00, d0[0]};
            3'b010:  c = {d2[2:0], d0[2:1], d1[0], 1'b1, 2'b01, d0[0]};
            3'b100:  c = {d0[2:1], d2[0], d1[2:0], 1'b1, 2'b10, d0[0]};
            3'b110:  c = {d0[2:1], d2[0], 2'b00, d1[0], 1'b1, 2'b11, d0[0]};
            3'b101:  c = {d1[2:1], d2[0], 2'b01, d1[0], 1'b1, 2'b11, d0[0]};
            3'b011:  c = {d2[2:0], 2'b10, d1[0], 1'b1, 2'b11, d0[0]};
            default: c = {2'b00, d2[0], 2'b11, d1[0], 1'b1, 2'b11, d0[0]};
        endcase
        return c;
    endfunction

    function automatic logic [11:0] mk_addr(int g, int s);
        return {10'(g), 2'(s)};
    endfunction

    function automatic ev_t mk_ev(int p, int d, int e, int c);
        ev_t v;
        v.port = p; v.digit = d; v.err = e; v.cyc = c;
        return v;
    endfunction

    // ROM models: junk on the bus except in the cycle the code is due.
    logic [9:0] rom1_pipe = 10'h2AA;
    logic [9:0] rom3_pipe [0:2] = '{10'h2AA, 10'h2AA, 10'h2AA};
    always @(posedge clk) begin
        rom1_pipe    <= rom_en ? dpd_enc(rom_num(int'(rom_addr))) : 10'h2AA;
        rom3_pipe[0] <= rom3_en ? dpd_enc(rom_num(int'(rom3_addr))) : 10'h2AA;
        rom3_pipe[1] <= rom3_pipe[0];
        rom3_pipe[2] <= rom3_pipe[1];
    end
    assign rom_code  = rom1_pipe;
    assign rom3_code = rom3_pipe[2];

    ev_t rx_q[$];
    ev_t exp_q[$];
    int  rom_en_cnt = 0;
    int  last_rom_addr = -1;

    // Response and ROM-strobe monitor for the ROM_LAT=1 instance.
    always @(negedge clk) begin
        if (s0v === 1'b1) rx_q.push_back(mk_ev(0, int'(s0d), int'(s0e), cyc));
        if (s1v === 1'b1) rx_q.push_back(mk_ev(1, int'(s1d), int'(s1e), cyc));
        if (rom_en === 1'b1) begin
            rom_en_cnt++;
            last_rom_addr = int'(rom_addr);
        end
    end

    task automatic issue(input int p, input logic [11:0] a, output int t_acc);
        bit got;
        got   = 1'b0;
        t_acc = -1;
        @(posedge clk); #1;
        if (p == 0) begin r0v = 1'b1; r0a = a; end
        else        begin r1v = 1'b1; r1a = a; end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if ((p == 0 && r0r === 1'b1) || (p == 1 && r1r === 1'b1)) begin
                got   = 1'b1;
                t_acc = cyc;
            end
        end
        @(posedge clk); #1;
        if (p == 0) r0v = 1'b0; else r1v = 1'b0;
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL accept port%0d addr %h: ready never seen in 40 cycles, required a handshake", p, a);
        end
    endtask

    task automatic get_rsp(output ev_t r);
        r = mk_ev(-1, -1, -1, -1);
        for (int i = 0; i < 30 && rx_q.size() == 0; i++) begin
            @(negedge clk); #1;
        end
        if (rx_q.size() > 0) r = rx_q.pop_front();
    endtask

    task automatic test_reset();
        r0v = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({r0r, r1r, s0v, s1v, s0e, s1e, s0d, s1d, rom_en, rom_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, required all zero", {r0r, r1r, s0v, s1v, s0e, s1e, s0d, s1d, rom_en, rom_addr});
        end
        n_tests++;
        if ({q0r, q1r, t0v, t1v, t0e, t1e, t0d, t1d, rom3_en, rom3_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_lat3: got %b, required all zero", {q0r, q1r, t0v, t1v, t0e, t1e, t0d, t1d, rom3_en, rom3_addr});
        end
        r0v = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_port0_triplet();
        int t; ev_t r, e; int en0;
        en0 = rom_en_cnt;
        for (int k = 0; k < 3; k++) begin
            issue(0, mk_addr(0, k), t);
            exp_q.push_back(mk_ev(0, exp_digit(0, k), 0, t + ((k == 0) ? 3 : 1)));
            get_rsp(r);
            e = exp_q.pop_front();
            n_tests++;
            if (r.port !== e.port || r.digit !== e.digit || r.err !== e.err || r.cyc !== e.cyc) begin
                n_fail++;
                $display("FAIL p0_read_sel%0d: got port %0d digit %0d err %0d cyc %0d, required port %0d digit %0d err %0d cyc %0d",
                         k, r.port, r.digit, r.err, r.cyc, e.port, e.digit, e.err, e.cyc);
            end
        end
        n_tests++;
        if (rom_en_cnt - en0 !== 1) begin
            n_fail++;
            $display("FAIL p0_rom_en_count: got %0d, required 1", rom_en_cnt - en0);
        end
    endtask

    task automatic test_port1_miss();
        int t; ev_t r, e; int en0;
        en0 = rom_en_cnt;
        issue(1, 12'h004, t);
        exp_q.push_back(mk_ev(1, exp_digit(1, 0), 0, t + 3));
        get_rsp(r);
        e = exp_q.pop_front();
        n_tests++;
        if (r.port !== e.port || r.digit !== e.digit || r.err !== e.err || r.cyc !== e.cyc) begin
            n_fail++;
            $display("FAIL p1_miss: got port %0d digit %0d err %0d cyc %0d, required port %0d digit %0d err %0d cyc %0d",
                     r.port, r.digit, r.err, r.cyc, e.port, e.digit, e.err, e.cyc);
        end
        n_tests++;
        if (rom_en_cnt - en0 !== 1 || last_rom_addr !== 1) begin
            n_fail++;
            $display("FAIL p1_rom_fetch: got %0d strobes addr %0d, required 1 strobe addr 1", rom_en_cnt - en0, last_rom_addr);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] a0 [0:2];
        logic [11:0] a1 [0:2];
        int g0 [0:2] = '{2, 2, 3};
        int s0 [0:2] = '{0, 1, 2};
        int g1 [0:2] = '{2, 3, 5};
        int s1 [0:2] = '{2, 0, 1};
        int order[$];
        int i0, i1, gp, both;
        ev_t r, e;
        for (int k = 0; k < 3; k++) begin
            a0[k] = mk_addr(g0[k], s0[k]);
            a1[k] = mk_addr(g1[k], s1[k]);
        end
        i0 = 0; i1 = 0; both = 0;
        @(posedge clk); #1;
        r0v = 1'b1; r0a = a0[0];
        r1v = 1'b1; r1a = a1[0];
        for (int c = 0; c < 200 && (i0 < 3 || i1 < 3); c++) begin
            @(negedge clk);
            if (r0r === 1'b1 && r1r === 1'b1) both++;
            gp = (r0r === 1'b1) ? 0 : ((r1r === 1'b1) ? 1 : -1);
            if (gp == 0) exp_q.push_back(mk_ev(0, exp_digit(g0[i0], s0[i0]), 0, -1));
            if (gp == 1) exp_q.push_back(mk_ev(1, exp_digit(g1[i1], s1[i1]), 0, -1));
            if (gp >= 0) order.push_back(gp);
            @(posedge clk); #1;
            if (gp == 0) begin i0++; if (i0 < 3) r0a = a0[i0]; else r0v = 1'b0; end
            if (gp == 1) begin i1++; if (i1 < 3) r1a = a1[i1]; else r1v = 1'b0; end
        end
        r0v = 1'b0; r1v = 1'b0;
        n_tests++;
        if (order.size() !== 6 || both !== 0) begin
            n_fail++;
            $display("FAIL rr_grants: got %0d grants %0d double-ready cycles, required 6 grants 0 double-ready", order.size(), both);
        end
        for (int k = 0; k < order.size() && k < 6; k++) begin
            n_tests++;
            if (order[k] !== k % 2) begin
                n_fail++;
                $display("FAIL rr_order%0d: got port %0d, required port %0d", k, order[k], k % 2);
            end
        end
        while (exp_q.size() > 0) begin
            get_rsp(r);
            e = exp_q.pop_front();
            n_tests++;
            if (r.port !== e.port || r.digit !== e.digit || r.err !== e.err) begin
                n_fail++;
                $display("FAIL rr_rsp: got port %0d digit %0d err %0d, required port %0d digit %0d err %0d",
                         r.port, r.digit, r.err, e.port, e.digit, e.err);
            end
        end
    endtask

    task automatic test_errors();
        logic [11:0] addrs [0:3] = '{12'h000, 12'h003, {10'd467, 2'b00}, 12'h000};
        int ports [0:3] = '{0, 1, 0, 1};
        int t; ev_t r, e; int en0;
        en0 = 0;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) en0 = rom_en_cnt;
            issue(ports[k], addrs[k], t);
            if (k == 1 || k == 2) exp_q.push_back(mk_ev(ports[k], 0, 1, t + 1));
            else                  exp_q.push_back(mk_ev(ports[k], 3, 0, t + ((k == 0) ? 3 : 1)));
            get_rsp(r);
            e = exp_q.pop_front();
            n_tests++;
            if (r.port !== e.port || r.digit !== e.digit || r.err !== e.err || r.cyc !== e.cyc) begin
                n_fail++;
                $display("FAIL err_seq%0d addr %h: got port %0d digit %0d err %0d cyc %0d, required port %0d digit %0d err %0d cyc %0d",
                         k, addrs[k], r.port, r.digit, r.err, r.cyc, e.port, e.digit, e.err, e.cyc);
            end
        end
        n_tests++;
        if (rom_en_cnt !== en0) begin
            n_fail++;
            $display("FAIL err_no_rom: got %0d strobes, required 0", rom_en_cnt - en0);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int t; ev_t r, e; int en0;
        issue(0, 12'h004, t);
        n_tests++;
        if (rom_en !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_in_fetch: got rom_en %b, required 1", rom_en);
        end
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({r0r, r1r, s0v, s1v, s0e, s1e, s0d, s1d, rom_en, rom_addr} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %b, required all zero", {r0r, r1r, s0v, s1v, s0e, s1e, s0d, s1d, rom_en, rom_addr});
        end
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        n_tests++;
        if (rx_q.size() !== 0) begin
            n_fail++;
            $display("FAIL midrst_no_rsp: got %0d responses, required 0", rx_q.size());
        end
        rx_q.delete();
        en0 = rom_en_cnt;
        issue(0, 12'h000, t);
        exp_q.push_back(mk_ev(0, 3, 0, t + 3));
        get_rsp(r);
        e = exp_q.pop_front();
        n_tests++;
        if (r.port !== e.port || r.digit !== e.digit || r.err !== e.err || r.cyc !== e.cyc || rom_en_cnt - en0 !== 1) begin
            n_fail++;
            $display("FAIL midrst_refetch: got port %0d digit %0d err %0d cyc %0d strobes %0d, required port %0d digit %0d err %0d cyc %0d strobes 1",
                     r.port, r.digit, r.err, r.cyc, rom_en_cnt - en0, e.port, e.digit, e.err, e.cyc);
        end
    endtask

    task automatic test_lat3_miss();
        int t, got, got_cyc, got_dig, got_err, en_bad, hold_bad, stray;
        ev_t e;
        t = -1; got = 0; got_cyc = -1; got_dig = -1; got_err = -1;
        en_bad = 0; hold_bad = 0; stray = 0;
        @(posedge clk); #1;
        q0v = 1'b1; q0a = mk_addr(466, 1);
        for (int i = 0; i < 40 && t < 0; i++) begin
            @(negedge clk);
            if (q0r === 1'b1) t = cyc;
        end
        @(posedge clk); #1;
        q0v = 1'b0;
        exp_q.push_back(mk_ev(0, exp_digit(466, 1), 0, t + 5));
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (rom3_en !== (c == 1)) en_bad++;
            if (c <= 4 && rom3_addr !== 10'd466) hold_bad++;
            if (t0v === 1'b1) begin
                got++; got_cyc = cyc; got_dig = int'(t0d); got_err = int'(t0e);
            end
            if (t1v !== 1'b0 || t1e !== 1'b0 || t1d !== 4'd0 || q1r !== 1'b0) stray++;
        end
        e = exp_q.pop_front();
        n_tests++;
        if (got !== 1 || got_cyc !== e.cyc || got_dig !== e.digit || got_err !== e.err) begin
            n_fail++;
            $display("FAIL lat3_rsp: got %0d rsp cyc %0d digit %0d err %0d, required 1 rsp cyc %0d digit %0d err %0d",
                     got, got_cyc, got_dig, got_err, e.cyc, e.digit, e.err);
        end
        n_tests++;
        if (en_bad !== 0 || hold_bad !== 0) begin
            n_fail++;
            $display("FAIL lat3_rom_bus: got %0d bad strobe cycles %0d unstable addr cycles, required 0 and 0", en_bad, hold_bad);
        end
        n_tests++;
        if (stray !== 0) begin
            n_fail++;
            $display("FAIL lat3_port1_quiet: got %0d active cycles, required 0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_port0_triplet();
        test_port1_miss();
        test_back_to_back();
        test_errors();
        test_reset_mid_fetch();
        test_lat3_miss();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
